// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with flush/stall control, a three-state occupancy FSM and a long-hold monitor.
// Optional stall/flush performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_stage_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_write,
    input  logic        flush,
    input  logic [31:0] pc_plus4_IF,
    input  logic [31:0] instr_IF,
    input  logic        instr_valid_IF,
    output logic [31:0] pc_plus4_ID,
    output logic [31:0] instr_ID,
    output logic        valid_ID,
    output logic [4:0]  rs_IF_ID,
    output logic [4:0]  rt_IF_ID,
    output logic        held_ID,
    output logic        hold_overflow,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_LOADED = 2'd1,
        ST_HELD   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, held_q;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic        overflow_q, overflow_d;

    // NOTE: every next-state signal gets a default at the top of the block so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        hold_cnt_d = 4'd0;
        overflow_d = overflow_q;

        if (flush) begin
            state_d = ST_EMPTY;
            instr_d = NOP;
        end else if (!PC_write) begin
            state_d = (state_q == ST_EMPTY) ? ST_EMPTY : ST_HELD;
        end else begin
            pc_d    = pc_plus4_IF;
            instr_d = instr_valid_IF ? instr_IF : NOP;
            state_d = instr_valid_IF ? ST_LOADED : ST_EMPTY;
        end

        // Count the cycle being entered in HELD, so the 15th held cycle already shows the flag.
        if (state_d == ST_HELD) begin
            hold_cnt_d = (hold_cnt_q == 4'hF) ? 4'hF : hold_cnt_q + 4'd1;
            if (hold_cnt_d == 4'hF) begin
                overflow_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            pc_q       <= 32'd0;
            instr_q    <= NOP;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
            hold_cnt_q <= 4'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= (state_d != ST_EMPTY);
            held_q     <= (state_d == ST_HELD);
            hold_cnt_q <= hold_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign pc_plus4_ID   = pc_q;
    assign instr_ID      = instr_q;
    assign valid_ID      = valid_q;
    assign held_ID       = held_q;
    assign hold_overflow = overflow_q;
    assign rs_IF_ID      = instr_q[25:21];
    assign rt_IF_ID      = instr_q[20:16];

`ifdef IF_ID_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            if (!flush && !PC_write && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = 16'd0;
    assign flush_count = 16'd0;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: directed scenarios plus random traffic against a behavioural model.
module tb_if_id_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PC_write = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] pc_plus4_IF = '0;
    logic [31:0] instr_IF = '0;
    logic        instr_valid_IF = 1'b0;
    logic [31:0] pc_plus4_ID;
    logic [31:0] instr_ID;
    logic        valid_ID;
    logic [4:0]  rs_IF_ID;
    logic [4:0]  rt_IF_ID;
    logic        held_ID;
    logic        hold_overflow;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: plain values, no FSM encoding.
    logic [31:0] m_pc, m_instr;
    bit          m_valid, m_held, m_ovf;
    int          m_run, m_stalls, m_flushes;

`ifdef IF_ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    if_id_stage_reg dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .PC_write       (PC_write),
        .flush          (flush),
        .pc_plus4_IF    (pc_plus4_IF),
        .instr_IF       (instr_IF),
        .instr_valid_IF (instr_valid_IF),
        .pc_plus4_ID    (pc_plus4_ID),
        .instr_ID       (instr_ID),
        .valid_ID       (valid_ID),
        .rs_IF_ID       (rs_IF_ID),
        .rt_IF_ID       (rt_IF_ID),
        .held_ID        (held_ID),
        .hold_overflow  (hold_overflow),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit pcw, input bit fl,
                                input logic [31:0] pc, input logic [31:0] ins, input bit v);
        if (!rst) begin
            m_pc = 0; m_instr = 0; m_valid = 0; m_held = 0; m_ovf = 0;
            m_run = 0; m_stalls = 0; m_flushes = 0;
        end else if (fl) begin
            m_instr = 0; m_valid = 0; m_held = 0; m_run = 0;
            if (m_flushes < 65535) m_flushes++;
        end else if (!pcw) begin
            m_held = m_valid;
            m_run  = m_held ? ((m_run < 15) ? m_run + 1 : 15) : 0;
            if (m_run == 15) m_ovf = 1;
            if (m_stalls < 65535) m_stalls++;
        end else begin
            m_pc = pc; m_valid = v; m_instr = v ? ins : 32'd0; m_held = 0; m_run = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pc"},    pc_plus4_ID, m_pc);
        check({tag, "_instr"}, instr_ID, m_instr);
        check({tag, "_valid"}, {31'd0, valid_ID}, {31'd0, m_valid});
        check({tag, "_rs"},    {27'd0, rs_IF_ID}, {27'd0, m_instr[25:21]});
        check({tag, "_rt"},    {27'd0, rt_IF_ID}, {27'd0, m_instr[20:16]});
        check({tag, "_held"},  {31'd0, held_ID}, {31'd0, m_held});
        check({tag, "_ovf"},   {31'd0, hold_overflow}, {31'd0, m_ovf});
        check({tag, "_stcnt"}, {16'd0, stall_count}, PERF ? m_stalls : 0);
        check({tag, "_flcnt"}, {16'd0, flush_count}, PERF ? m_flushes : 0);
    endtask

    // One clock: drive on the falling edge, let the rising edge pass, compare 1 ns later.
    task automatic step(input string tag, input bit rst, input bit pcw, input bit fl,
                        input logic [31:0] pc, input logic [31:0] ins, input bit v);
        @(negedge clk);
        rst_n = rst; PC_write = pcw; flush = fl;
        pc_plus4_IF = pc; instr_IF = ins; instr_valid_IF = v;
        @(posedge clk);
        model_update(rst, pcw, fl, pc, ins, v);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset, then a valid load of lw $2,4($1).
        step("rst", 0, 1, 0, 32'h0, 32'h0, 0);
        check("rst_instr_nop", instr_ID, 32'h0);
        step("ld1", 1, 1, 0, 32'h0000_0104, 32'h8C22_0004, 1);
        check("ld1_rs", {27'd0, rs_IF_ID}, 32'd1);
        check("ld1_rt", {27'd0, rt_IF_ID}, 32'd2);
        check("ld1_valid", {31'd0, valid_ID}, 32'd1);

        // Two-cycle load-use stall, then advance.
        step("st1", 1, 0, 0, 32'h0000_0108, 32'h1111_1111, 1);
        step("st2", 1, 0, 0, 32'h0000_0108, 32'h1111_1111, 1);
        check("st2_instr_held", instr_ID, 32'h8C22_0004);
        check("st2_held", {31'd0, held_ID}, 32'd1);
        step("adv", 1, 1, 0, 32'h0000_0108, 32'h0043_2020, 1);
        check("adv_held", {31'd0, held_ID}, 32'd0);

        // Flush together with a stall: flush wins.
        step("flst", 1, 0, 1, 32'h0000_010C, 32'h2222_2222, 1);
        check("flst_instr", instr_ID, 32'h0);
        check("flst_pc_kept", pc_plus4_ID, 32'h0000_0108);

        // 16-cycle stall: flag appears on the 15th HELD cycle and survives release.
        step("ld2", 1, 1, 0, 32'h0000_0200, 32'h1234_5678, 1);
        for (int i = 1; i <= 16; i++) begin
            step("long", 1, 0, 0, 32'h0000_0204, 32'hDEAD_BEEF, 1);
            check("long_ovf", {31'd0, hold_overflow}, (i >= 15) ? 32'd1 : 32'd0);
        end
        step("rel", 1, 1, 0, 32'h0000_0204, 32'h0000_0001, 1);
        check("rel_ovf", {31'd0, hold_overflow}, 32'd1);

        // Reset in mid-HELD, with flush and stall also asserted.
        step("ld3", 1, 1, 0, 32'h0000_0300, 32'h03E0_0008, 1);
        step("h3a", 1, 0, 0, 32'h0, 32'h0, 0);
        step("h3b", 1, 0, 0, 32'h0, 32'h0, 0);
        step("rst2", 0, 0, 1, 32'h0, 32'h0, 0);
        check("rst2_held", {31'd0, held_ID}, 32'd0);
        check("rst2_ovf", {31'd0, hold_overflow}, 32'd0);

        // Load of an invalid fetch, then stall while empty.
        step("inv", 1, 1, 0, 32'h0000_0400, 32'hFFFF_FFFF, 0);
        check("inv_instr", instr_ID, 32'h0);
        step("inv_st", 1, 0, 0, 32'h0000_0404, 32'hFFFF_FFFF, 1);
        check("inv_st_held", {31'd0, held_ID}, 32'd0);
        check("inv_st_valid", {31'd0, valid_ID}, 32'd0);

        // Random traffic, with occasional long stall bursts.
        for (int c = 0; c < 600; c++) begin
            bit r, p, f, v;
            r = ($urandom_range(63) != 0);
            f = ($urandom_range(7) == 0);
            p = ((c / 40) % 3 == 2) ? ($urandom_range(15) == 0) : ($urandom_range(2) != 0);
            v = ($urandom_range(4) != 0);
            step("rnd", r, p, f, $urandom, $urandom, v);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
